// File: rtl/uio_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : uio_mem_responder
//  Brief    : Responder side of the multiplexed 8-bit external-memory bus.
//             Latches an address on ale, stores write data into a 256x8 RAM,
//             returns read data after READ_LAT cycles, acknowledges each
//             access with a one-cycle rdy and flags protocol misuse on err.
//  Revision : 1.0  initial release
// ============================================================================
module uio_mem_responder #(
  parameter int READ_LAT = 1,  // 1..4 cycles from rd sample to data valid
  parameter int AUTO_INC = 1   // 1: post-increment address after each access
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_in,
  input  logic       ale,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       rdy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,  // no valid address latched yet
    S_READY    = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_DRIVE = 2'd3
  } state_t;

  localparam logic [7:0] ADDR_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;
  // Countdown preload: RD_WAIT leaves when the counter reaches 1, so a
  // preload of READ_LAT-1 yields data exactly READ_LAT edges after rd.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

  logic [7:0] mem [256];

  state_t     state_q,   state_d;
  logic [7:0] addr_q,    addr_d;
  logic [1:0] cnt_q,     cnt_d;
  logic [7:0] rdata_q,   rdata_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q,  bus_oe_d;
  logic       rdy_q,     rdy_d;
  logic       err_q,     err_d;
  logic       mem_we;

  logic any_stb;
  logic multi_stb;
  assign any_stb   = ale | wr | rd;
  assign multi_stb = (ale & wr) | (ale & rd) | (wr & rd);

  // Next-state, address, read-capture and output decode for the bus protocol.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_out_d = 8'h00;
    bus_oe_d  = 1'b0;
    rdy_d     = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr || rd) begin
          err_d = 1'b1;
        end else if (ale) begin
          addr_d  = bus_in;
          state_d = S_READY;
        end
      end

      S_READY: begin
        if (multi_stb) begin
          err_d = 1'b1;
        end else if (ale) begin
          addr_d = bus_in;
        end else if (wr) begin
          mem_we = 1'b1;
          addr_d = addr_q + ADDR_STEP;
          rdy_d  = 1'b1;
        end else if (rd) begin
          rdata_d = mem[addr_q];
          addr_d  = addr_q + ADDR_STEP;
          if (READ_LAT <= 1) begin
            // Single-cycle latency: present the data right away.
            state_d   = S_RD_DRIVE;
            bus_out_d = mem[addr_q];
            bus_oe_d  = 1'b1;
            rdy_d     = 1'b1;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (any_stb) begin
          err_d = 1'b1;
        end
        if (cnt_q <= 2'd1) begin
          state_d   = S_RD_DRIVE;
          bus_out_d = rdata_q;
          bus_oe_d  = 1'b1;
          rdy_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      S_RD_DRIVE: begin
        if (any_stb) begin
          err_d = 1'b1;
        end
        state_d = S_READY;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 8'h00;
      cnt_q     <= 2'd0;
      rdata_q   <= 8'h00;
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  // RAM array: contents survive reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= bus_in;
    end
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign rdy     = rdy_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uio_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uio_mem_responder
//  Brief    : Directed bench for uio_mem_responder. Four instances cover the
//             parameter corners: [0] LAT1/INC1, [1] LAT3/INC1,
//             [2] LAT1/INC0, [3] LAT4/INC1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uio_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [4];
  logic [7:0] bus_in  [4];
  logic       ale     [4];
  logic       wr      [4];
  logic       rd      [4];
  logic [7:0] bus_out [4];
  logic       bus_oe  [4];
  logic       rdy     [4];
  logic       err     [4];

  int n_vec = 0;
  int n_bad = 0;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = (g == 1) ? 3 : (g == 3) ? 4 : 1;
      localparam int INC = (g == 2) ? 0 : 1;
      uio_mem_responder #(.READ_LAT(LAT), .AUTO_INC(INC)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n[g]),
        .bus_in  (bus_in[g]),
        .ale     (ale[g]),
        .wr      (wr[g]),
        .rd      (rd[g]),
        .bus_out (bus_out[g]),
        .bus_oe  (bus_oe[g]),
        .rdy     (rdy[g]),
        .err     (err[g])
      );
    end
  endgenerate

  typedef struct {
    logic       a;
    logic       w;
    logic       r;
    logic [7:0] din;
    logic       eoe;
    logic       erdy;
    logic [7:0] eout;
    logic       eerr;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic w, input logic r,
                              input logic [7:0] din, input logic eoe,
                              input logic erdy, input logic [7:0] eout,
                              input logic eerr);
    vec_t v;
    v.a = a; v.w = w; v.r = r; v.din = din;
    v.eoe = eoe; v.erdy = erdy; v.eout = eout; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input int k, input string nm, input logic eoe,
                       input logic erdy, input logic [7:0] eout,
                       input logic eerr);
    n_vec++;
    if ({bus_oe[k], rdy[k], bus_out[k], err[k]} !== {eoe, erdy, eout, eerr}) begin
      n_bad++;
      $display("FAIL %s dut%0d: got oe=%b rdy=%b out=%02h err=%b, want oe=%b rdy=%b out=%02h err=%b",
               nm, k, bus_oe[k], rdy[k], bus_out[k], err[k], eoe, erdy, eout, eerr);
    end
  endtask

  // Drive one cycle of strobes, then check outputs just after the edge.
  task automatic cyc(input int k, input logic a, input logic w, input logic r,
                     input logic [7:0] d, input string nm, input logic eoe,
                     input logic erdy, input logic [7:0] eout, input logic eerr);
    ale[k] = a; wr[k] = w; rd[k] = r; bus_in[k] = d;
    @(posedge clk);
    #1;
    ale[k] = 1'b0; wr[k] = 1'b0; rd[k] = 1'b0; bus_in[k] = 8'h00;
    check(k, nm, eoe, erdy, eout, eerr);
  endtask

  vec_t tbl [12];

  initial begin
    // Burst table for instance 0 (LAT1, INC1): wr before ale -> err.
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 8'h00, 1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b1, 8'h00, 1'b1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0; bus_in[k] = 8'h00;
      ale[k] = 1'b0; wr[k] = 1'b0; rd[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check(k, "reset", 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;

    // Instance 0: table-driven idle-error and burst write/read.
    for (int i = 0; i < 12; i++) begin
      cyc(0, tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].din, $sformatf("burst%0d", i),
          tbl[i].eoe, tbl[i].erdy, tbl[i].eout, tbl[i].eerr);
    end

    // Instance 1: address wrap with 3-cycle read latency.
    cyc(1, 1'b1, 1'b0, 1'b0, 8'hFF, "wrap_ale",   1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b1, 1'b0, 8'h11, "wrap_wr1",   1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b1, 1'b0, 8'h22, "wrap_wr2",   1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1, 1'b1, 1'b0, 1'b0, 8'hFF, "wrap_ale2",  1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "wrap_rd1",   1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_lat1",  1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_data1", 1'b1, 1'b1, 8'h11, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_gap",   1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "wrap_rd2",   1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_lat2",  1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_data2", 1'b1, 1'b1, 8'h22, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_end",   1'b0, 1'b0, 8'h00, 1'b0);

    // Instance 1: protocol errors; address and RAM must be untouched.
    cyc(1, 1'b1, 1'b0, 1'b0, 8'h00, "p_ale",      1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1, 1'b0, 1'b1, 1'b1, 8'h99, "p_rdwr",     1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "p_rd",       1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "p_rd_wait",  1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "p_data",     1'b1, 1'b1, 8'h22, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "p_rd_drive", 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "p_quiet",    1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b1, 1'b0, 1'b0, 8'hFF, "p_ale2",     1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b1, 8'h00, "p_rd2",      1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "p_lat2",     1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1, 1'b0, 1'b0, 1'b0, 8'h00, "p_data2",    1'b1, 1'b1, 8'h11, 1'b1);

    // Instance 2: no auto-increment; read right after write, same address.
    cyc(2, 1'b1, 1'b0, 1'b0, 8'h20, "ninc_ale",   1'b0, 1'b0, 8'h00, 1'b0);
    cyc(2, 1'b0, 1'b1, 1'b0, 8'h01, "ninc_wr1",   1'b0, 1'b1, 8'h00, 1'b0);
    cyc(2, 1'b0, 1'b1, 1'b0, 8'h02, "ninc_wr2",   1'b0, 1'b1, 8'h00, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b1, 8'h00, "ninc_rd",    1'b1, 1'b1, 8'h02, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0, 8'h00, "ninc_end",   1'b0, 1'b0, 8'h00, 1'b0);

    // Instance 3: reset asserted while a 4-cycle read is in flight.
    cyc(3, 1'b1, 1'b0, 1'b0, 8'h40, "rst_ale",    1'b0, 1'b0, 8'h00, 1'b0);
    cyc(3, 1'b0, 1'b1, 1'b0, 8'h77, "rst_wr",     1'b0, 1'b1, 8'h00, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b1, 8'h00, "rst_rd",     1'b0, 1'b0, 8'h00, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_w1",     1'b0, 1'b0, 8'h00, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_w2",     1'b0, 1'b0, 8'h00, 1'b0);
    rst_n[3] = 1'b0;
    #1;
    check(3, "rst_assert", 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check(3, "rst_hold", 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, $sformatf("rst_quiet%0d", i),
          1'b0, 1'b0, 8'h00, 1'b0);
    end
    cyc(3, 1'b0, 1'b0, 1'b1, 8'h00, "rst_idle_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(3, 1'b1, 1'b0, 1'b0, 8'h40, "rst_ale2",    1'b0, 1'b0, 8'h00, 1'b1);
    cyc(3, 1'b0, 1'b0, 1'b1, 8'h00, "rst_rd2",     1'b0, 1'b0, 8'h00, 1'b1);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_lat_a",   1'b0, 1'b0, 8'h00, 1'b1);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_lat_b",   1'b0, 1'b0, 8'h00, 1'b1);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_keep",    1'b1, 1'b1, 8'h77, 1'b1);
    cyc(3, 1'b0, 1'b0, 1'b0, 8'h00, "rst_end",     1'b0, 1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
